// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO control types: occupancy state of the pointer controller.
package fifo_ctrl_pkg;
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifoState_t;
endpackage

// File: rtl/fifo_ptr_cnt.sv
// ADDR_W-bit wrap counter; natural binary wrap since DEPTH is a power of two.
module fifo_ptr_cnt #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en,
  input  logic              clr,
  output logic [ADDR_W-1:0] ptr
);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (en)  ptr <= ptr + ADDR_W'(1);
  end
endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/occupancy controller for an external register file,
// with overwrite-on-full, synchronous flush and sticky error flags.
module fifo_ptr_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic              overwrite_en,
  output logic              wEnable,
  output logic [ADDR_W-1:0] wptr,
  output logic [ADDR_W-1:0] rptr,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overrun,
  output logic              underrun
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);

  fifoState_t      state, stateNxt;
  logic [ADDR_W:0] countNxt;
  logic            pushAcc, popAcc, rdAdv;
  logic            ovrNxt, undNxt, emptyNxt, fullNxt, afNxt;

  always_comb begin
    pushAcc  = push && ((state != FULL) || pop || overwrite_en);
    popAcc   = pop && (state != EMPTY);
    // Overwrite on full retires the oldest entry, so rptr moves with wptr.
    rdAdv    = popAcc || (pushAcc && (state == FULL) && !pop);
    wEnable  = pushAcc && !clear && n_rst;
    countNxt = count;
    ovrNxt   = overrun;
    undNxt   = underrun;
    if (clear) begin
      countNxt = '0;
      ovrNxt   = 1'b0;
      undNxt   = 1'b0;
    end else begin
      if (pushAcc && !rdAdv)      countNxt = count + (ADDR_W+1)'(1);
      else if (rdAdv && !pushAcc) countNxt = count - (ADDR_W+1)'(1);
      if (push && (state == FULL) && !pop) ovrNxt = 1'b1;
      if (pop && (state == EMPTY))         undNxt = 1'b1;
    end
    if (countNxt == '0)          stateNxt = EMPTY;
    else if (countNxt == DEPTH_C) stateNxt = FULL;
    else                          stateNxt = PARTIAL;
    emptyNxt = (countNxt == '0);
    fullNxt  = (countNxt == DEPTH_C);
    afNxt    = (countNxt >= AF_C);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= EMPTY;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overrun     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= stateNxt;
      count       <= countNxt;
      empty       <= emptyNxt;
      full        <= fullNxt;
      almost_full <= afNxt;
      overrun     <= ovrNxt;
      underrun    <= undNxt;
    end
  end

  fifo_ptr_cnt #(.ADDR_W(ADDR_W)) uWptr (
    .clk(clk), .n_rst(n_rst), .en(pushAcc), .clr(clear), .ptr(wptr)
  );

  fifo_ptr_cnt #(.ADDR_W(ADDR_W)) uRptr (
    .clk(clk), .n_rst(n_rst), .en(rdAdv), .clr(clear), .ptr(rptr)
  );
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: directed vector table, hand sequences, random vs model.
module tb_fifo_ptr_ctrl;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;

  logic       clk = 1'b0;
  logic       n_rst, push, pop, clear, overwrite_en;
  logic       wEnable, empty, full, almost_full, overrun, underrun;
  logic [2:0] wptr, rptr;
  logic [3:0] count;

  int nChecks = 0;
  int nFail   = 0;

  fifo_ptr_ctrl #(.DEPTH(DEPTH), .ADDR_W(3), .AF_THRESH(AFT)) dut (
    .clk(clk), .n_rst(n_rst), .push(push), .pop(pop), .clear(clear),
    .overwrite_en(overwrite_en), .wEnable(wEnable), .wptr(wptr), .rptr(rptr),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit p, q, c, o;
    int wen, wp, rp, cnt, af, ovr, und;
  } vec_t;

  vec_t tbl[$];

  // behavioural model: occupancy and pointer positions as plain integers
  int mCnt, mWp, mRp;
  bit mOvr, mUnd;

  task automatic chk(input string nm, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit p, bit q, bit c, bit o, int wen, int wp, int rp,
                              int cnt, int ovr, int und);
    vec_t v;
    v.p = p; v.q = q; v.c = c; v.o = o; v.wen = wen; v.wp = wp; v.rp = rp;
    v.cnt = cnt; v.af = (cnt >= AFT); v.ovr = ovr; v.und = und;
    return v;
  endfunction

  function automatic int mWen(bit p, bit q, bit c, bit o);
    if (c) return 0;
    return (p && (mCnt < DEPTH || q || o)) ? 1 : 0;
  endfunction

  task automatic mStep(input bit p, input bit q, input bit c, input bit o);
    bit doPush, doPop;
    if (c) begin
      mCnt = 0; mWp = 0; mRp = 0; mOvr = 0; mUnd = 0;
    end else begin
      doPush = p && (mCnt < DEPTH || q || o);
      doPop  = (q && mCnt > 0) || (p && !q && o && mCnt == DEPTH);
      if (p && !q && mCnt == DEPTH) mOvr = 1;
      if (q && mCnt == 0) mUnd = 1;
      if (doPush) mWp = (mWp + 1) % DEPTH;
      if (doPop)  mRp = (mRp + 1) % DEPTH;
      mCnt = mCnt + int'(doPush) - int'(doPop);
    end
  endtask

  task automatic checkModel(input string tag);
    chk({tag, ".wptr"}, wptr, mWp);
    chk({tag, ".rptr"}, rptr, mRp);
    chk({tag, ".count"}, count, mCnt);
    chk({tag, ".empty"}, empty, mCnt == 0);
    chk({tag, ".full"}, full, mCnt == DEPTH);
    chk({tag, ".afull"}, almost_full, mCnt >= AFT);
    chk({tag, ".overrun"}, overrun, mOvr);
    chk({tag, ".underrun"}, underrun, mUnd);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, ".wEnable"}, wEnable, 0);
    chk({tag, ".wptr"}, wptr, 0);
    chk({tag, ".rptr"}, rptr, 0);
    chk({tag, ".count"}, count, 0);
    chk({tag, ".empty"}, empty, 1);
    chk({tag, ".full"}, full, 0);
    chk({tag, ".afull"}, almost_full, 0);
    chk({tag, ".overrun"}, overrun, 0);
    chk({tag, ".underrun"}, underrun, 0);
  endtask

  // called at posedge+1: drive, sample combinational strobe, cross the edge
  task automatic cyc(input bit p, input bit q, input bit c, input bit o, output int wenSeen);
    push = p; pop = q; clear = c; overwrite_en = o;
    #3 wenSeen = wEnable;
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    n_rst = 1'b0; push = 0; pop = 0; clear = 0; overwrite_en = 0;
    #12 checkReset("reset");
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;

    // 8 pushes to full, drop-on-full, overwrite, clear, underrun, push+pop streaming
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1,0,0,0, 1, (i+1)%8, 0, i+1, 0, 0));
    tbl.push_back(mk(1,0,0,0, 0, 0, 0, 8, 1, 0));
    tbl.push_back(mk(1,0,0,1, 1, 1, 1, 8, 1, 0));
    tbl.push_back(mk(0,0,1,0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,0,0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0,0,1,0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0, 1, i+1, 0, i+1, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1,1,0,0, 1, (4+i)%8, i+1, 3, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      if (i < 8) chk({t, ".wptrPre"}, wptr, i);
      cyc(tbl[i].p, tbl[i].q, tbl[i].c, tbl[i].o, w);
      chk({t, ".wEnable"}, w, tbl[i].wen);
      chk({t, ".wptr"}, wptr, tbl[i].wp);
      chk({t, ".rptr"}, rptr, tbl[i].rp);
      chk({t, ".count"}, count, tbl[i].cnt);
      chk({t, ".empty"}, empty, tbl[i].cnt == 0);
      chk({t, ".full"}, full, tbl[i].cnt == DEPTH);
      chk({t, ".afull"}, almost_full, tbl[i].af);
      chk({t, ".overrun"}, overrun, tbl[i].ovr);
      chk({t, ".underrun"}, underrun, tbl[i].und);
    end

    // push and pop together while empty: push wins, underrun flagged
    cyc(0,0,1,0, w);
    cyc(1,1,0,0, w);
    chk("pushPopEmpty.wEnable", w, 1);
    chk("pushPopEmpty.count", count, 1);
    chk("pushPopEmpty.rptr", rptr, 0);
    chk("pushPopEmpty.underrun", underrun, 1);
    for (int i = 0; i < 4; i++) cyc(1,0,0,0, w);
    chk("preReset.count", count, 5);

    // asynchronous reset between edges with push still requested
    push = 1'b1;
    @(negedge clk); #2 n_rst = 1'b0;
    #1 checkReset("asyncReset");
    push = 1'b0;
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;

    mCnt = 0; mWp = 0; mRp = 0; mOvr = 0; mUnd = 0;
    for (int i = 0; i < 400; i++) begin
      bit p, q, c, o;
      int ew;
      p = ($urandom % 3) != 0;
      q = ($urandom % 2) != 0;
      c = ($urandom % 25) == 0;
      o = ($urandom % 2) != 0;
      ew = mWen(p, q, c, o);
      chk("rand.wptrPre", wptr, mWp);
      cyc(p, q, c, o, w);
      chk("rand.wEnable", w, ew);
      mStep(p, q, c, o);
      checkModel("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
